// File: rtl/apa102_rx_frame.sv
// APA102 LED-stream receiver: start-frame hunt, shadow capture, atomic commit.
// Optional LED-header check enabled by defining APA102_RX_HDR_CHECK_EN.
module apa102_rx_frame #(
    parameter int unsigned NUM_LEDS     = 7,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned IDLE_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sck,
    input  logic                     sda,
    output logic [32*NUM_LEDS-1:0]   data_out,
    output logic                     frame_valid,
    output logic                     frame_error,
    output logic                     busy
);
    localparam int unsigned DATA_W = 32 * NUM_LEDS;
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int unsigned ZERO_W = 6;

    typedef enum logic {HUNT, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, sda_sync;
    logic                   sck_d, sck_rise, sda_bit;

    state_t              state, state_nxt;
    logic [ZERO_W-1:0]   zero_cnt, zero_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic [DATA_W-1:0]   shadow, shadow_nxt, shift_val;
    logic [DATA_W-1:0]   data_nxt;
    logic                valid_nxt, error_nxt, busy_nxt;
    logic                hdr_ok, timeout_hit;

    // Synchronisers plus edge detect; sda gets a matching extra flop to stay aligned with sck_rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync <= '0;
            sda_sync <= '0;
            sck_d    <= 1'b0;
            sck_rise <= 1'b0;
            sda_bit  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_d;
            sda_bit  <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign shift_val   = {shadow[DATA_W-2:0], sda_bit};
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

`ifdef APA102_RX_HDR_CHECK_EN
    always_comb begin
        hdr_ok = 1'b1;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            if (shift_val[DATA_W-1-32*i -: 3] != 3'b111) hdr_ok = 1'b0;
        end
    end
`else
    assign hdr_ok = 1'b1;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            zero_cnt    <= '0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            shadow      <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            zero_cnt    <= zero_nxt;
            bit_cnt     <= bit_nxt;
            idle_cnt    <= idle_nxt;
            shadow      <= shadow_nxt;
            data_out    <= data_nxt;
            frame_valid <= valid_nxt;
            frame_error <= error_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state logic; a final-bit sck_rise takes priority over the idle timeout.
    always_comb begin
        state_nxt  = state;
        zero_nxt   = zero_cnt;
        bit_nxt    = bit_cnt;
        idle_nxt   = '0;
        shadow_nxt = shadow;
        data_nxt   = data_out;
        valid_nxt  = 1'b0;
        error_nxt  = 1'b0;

        case (state)
            HUNT: begin
                if (sck_rise) begin
                    if (sda_bit) begin
                        zero_nxt = '0;
                    end else if (zero_cnt == ZERO_W'(31)) begin
                        zero_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        zero_nxt = zero_cnt + ZERO_W'(1);
                    end
                end
            end
            DATA: begin
                idle_nxt = idle_cnt + IDLE_W'(1);
                if (sck_rise) begin
                    idle_nxt   = '0;
                    shadow_nxt = shift_val;
                    bit_nxt    = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        state_nxt = HUNT;
                        zero_nxt  = '0;
                        if (hdr_ok) begin
                            data_nxt  = shift_val;
                            valid_nxt = 1'b1;
                        end else begin
                            error_nxt = 1'b1;
                        end
                    end
                end else if (timeout_hit) begin
                    idle_nxt  = '0;
                    state_nxt = HUNT;
                    zero_nxt  = '0;
                    error_nxt = 1'b1;
                end
            end
            default: state_nxt = HUNT;
        endcase

        busy_nxt = (state_nxt == DATA);
    end

endmodule

// File: tb/tb_apa102_rx_frame.sv
// Directed bench for apa102_rx_frame (NUM_LEDS=2, IDLE_TIMEOUT=64); honours APA102_RX_HDR_CHECK_EN.
module tb_apa102_rx_frame;
    localparam int unsigned NUM_LEDS     = 2;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned IDLE_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        sda;
    logic [63:0] data_out;
    logic        frame_valid;
    logic        frame_error;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0, error_cnt = 0, wide_cnt = 0;
    logic valid_prev = 1'b0, error_prev = 1'b0;

    apa102_rx_frame #(
        .NUM_LEDS    (NUM_LEDS),
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .sda        (sda),
        .data_out   (data_out),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and width watchdog, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_error) error_cnt++;
        if ((frame_valid && valid_prev) || (frame_error && error_prev)) wide_cnt++;
        valid_prev = frame_valid;
        error_prev = frame_error;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda = b;
        tick(4);
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b);
        send_bits(32'h0, 32);
        send_bits(a, 32);
        send_bits(b, 32);
        tick(4);
    endtask

    logic [63:0] exp_data;
    int          v0, e0, cnt;

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        sda   = 1'b0;
        tick(3);
        check("rst_data", data_out, 64'h0);
        check("rst_valid", 64'(frame_valid), 64'h0);
        check("rst_error", 64'(frame_error), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        tick(2);

        // Basic frame
        v0 = valid_cnt; e0 = error_cnt;
        send_frame(32'hE1112233, 32'hFF445566);
        check("f1_data", data_out, 64'hE1112233_FF445566);
        check("f1_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("f1_error_cnt", 64'(error_cnt - e0), 64'd0);
        check("f1_busy", 64'(busy), 64'h0);

        // Broken start: 31 zeros then a one, then a proper frame
        v0 = valid_cnt;
        send_bits(32'h0, 31);
        send_bit(1'b1);
        check("f2_busy_after_broken", 64'(busy), 64'h0);
        send_frame(32'hF0A0B0C0, 32'hE7654321);
        check("f2_data", data_out, 64'hF0A0B0C0_E7654321);
        check("f2_valid_cnt", 64'(valid_cnt - v0), 64'd1);

        // LED1 header 011
        v0 = valid_cnt; e0 = error_cnt;
        send_frame(32'hFFAABBCC, 32'h7F000000);
`ifdef APA102_RX_HDR_CHECK_EN
        exp_data = 64'hF0A0B0C0_E7654321;
        check("hdr_error_cnt", 64'(error_cnt - e0), 64'd1);
        check("hdr_valid_cnt", 64'(valid_cnt - v0), 64'd0);
`else
        exp_data = 64'hFFAABBCC_7F000000;
        check("hdr_error_cnt", 64'(error_cnt - e0), 64'd0);
        check("hdr_valid_cnt", 64'(valid_cnt - v0), 64'd1);
`endif
        check("hdr_data", data_out, exp_data);
        exp_data = data_out;

        // Idle timeout after 40 data bits
        e0 = error_cnt; v0 = valid_cnt;
        send_bits(32'h0, 32);
        send_bits(32'hEEEEEEEE, 32);
        send_bits(32'hEE000000, 8);
        check("to_busy_before", 64'(busy), 64'h1);
        cnt = 4;
        while (!frame_error && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("to_latency_ok", 64'((cnt >= int'(IDLE_TIMEOUT)) && (cnt <= int'(IDLE_TIMEOUT + SYNC_STAGES + 4))), 64'h1);
        if (cnt < 100) tick(100 - cnt);
        check("to_error_cnt", 64'(error_cnt - e0), 64'd1);
        check("to_busy_after", 64'(busy), 64'h0);
        check("to_data_held", data_out, exp_data);
        send_frame(32'hE0000001, 32'hE8000002);
        check("to_next_data", data_out, 64'hE0000001_E8000002);
        check("to_next_valid", 64'(valid_cnt - v0), 64'd1);

        // Back-to-back frames with end frame between
        v0 = valid_cnt;
        send_frame(32'hE5A5A5A5, 32'hFA5A5A5A);
        check("b2b_a_data", data_out, 64'hE5A5A5A5_FA5A5A5A);
        send_bits(32'hFFFFFFFF, 32);
        send_frame(32'hE1234567, 32'hF89ABCDE);
        check("b2b_b_data", data_out, 64'hE1234567_F89ABCDE);
        check("b2b_valid_cnt", 64'(valid_cnt - v0), 64'd2);

        // Reset in the middle of DATA
        send_bits(32'h0, 32);
        send_bits(32'hE3333333, 20);
        check("mid_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_data", data_out, 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h0);
        check("mid_rst_flags", 64'({frame_valid, frame_error}), 64'h0);
        rst_n = 1'b1;
        v0 = valid_cnt; e0 = error_cnt;
        send_bits(32'h33300000, 12);
        send_bits(32'hFCCCCCCC, 32);
        tick(4);
        check("mid_leftover_valid", 64'(valid_cnt - v0), 64'd0);
        check("mid_leftover_data", data_out, 64'h0);
        check("mid_leftover_busy", 64'(busy), 64'h0);
        send_bits(32'hFFFFFFFF, 32);
        send_frame(32'hE3333333, 32'hFCCCCCCC);
        check("mid_new_data", data_out, 64'hE3333333_FCCCCCCC);
        check("mid_new_valid", 64'(valid_cnt - v0), 64'd1);
        check("mid_new_error", 64'(error_cnt - e0), 64'd0);

        check("pulse_width", 64'(wide_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
